// File: rtl/sprite_compositor_if.sv
// State bus between the game core / VGA timing (master) and the sprite compositor (slave).
// Sprite records and the timing stream have no handshake: the compositor samples them every clock.
interface sprite_compositor_if;
  logic       frame_tick;
  logic       video_active;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic [9:0] posx0, posx1, posx2, posx3;
  logic [8:0] posy0, posy1, posy2, posy3;
  logic [2:0] color_idx0, color_idx1, color_idx2, color_idx3;
  logic [1:0] power_state0, power_state1, power_state2, power_state3;
  logic [5:0] rgb;
  logic       pix_valid;
  logic [3:0] sprite_hit;
  logic       collide;
  logic [4:0] frame_cnt;

  modport master (
    output frame_tick, video_active, hpos, vpos,
    output posx0, posx1, posx2, posx3, posy0, posy1, posy2, posy3,
    output color_idx0, color_idx1, color_idx2, color_idx3,
    output power_state0, power_state1, power_state2, power_state3,
    input  rgb, pix_valid, sprite_hit, collide, frame_cnt
  );

  modport slave (
    input  frame_tick, video_active, hpos, vpos,
    input  posx0, posx1, posx2, posx3, posy0, posy1, posy2, posy3,
    input  color_idx0, color_idx1, color_idx2, color_idx3,
    input  power_state0, power_state1, power_state2, power_state3,
    output rgb, pix_valid, sprite_hit, collide, frame_cnt
  );
endinterface

// File: rtl/sprite_compositor.sv
// Per-frame sprite snapshot plus a 2-stage pixel pipeline: stage 1 box/edge tests,
// stage 2 priority, palette and power-state effects. Also tracks per-frame sprite overlap.
module sprite_compositor #(
  parameter int         SCREEN_W = 640,
  parameter int         SCREEN_H = 480,
  parameter int         BOX_W    = 48,
  parameter int         BOX_H    = 32,
  parameter logic [5:0] BG_RGB   = 6'b000001
) (
  input logic             clk,
  input logic             rst_n,
  sprite_compositor_if.slave bus
);

  logic [9:0] posx_in [4];
  logic [8:0] posy_in [4];
  logic [2:0] col_in  [4];
  logic [1:0] ps_in   [4];

  assign posx_in[0] = bus.posx0;        assign posx_in[1] = bus.posx1;
  assign posx_in[2] = bus.posx2;        assign posx_in[3] = bus.posx3;
  assign posy_in[0] = bus.posy0;        assign posy_in[1] = bus.posy1;
  assign posy_in[2] = bus.posy2;        assign posy_in[3] = bus.posy3;
  assign col_in[0]  = bus.color_idx0;   assign col_in[1]  = bus.color_idx1;
  assign col_in[2]  = bus.color_idx2;   assign col_in[3]  = bus.color_idx3;
  assign ps_in[0]   = bus.power_state0; assign ps_in[1]   = bus.power_state1;
  assign ps_in[2]   = bus.power_state2; assign ps_in[3]   = bus.power_state3;

  logic [9:0] sx_q  [4];
  logic [8:0] sy_q  [4];
  logic [2:0] col_q [4];
  logic [1:0] ps_q  [4];
  logic [4:0] frame_cnt_q;
  logic       collide_q, collide_acc_q;
  logic [3:0] inside_d, edge_d, inside_q, edge_q;
  logic       active_q;
  logic [5:0] rgb_d, rgb_q;
  logic       pix_valid_q;
  logic [3:0] hit_q;

  // Box bounds are widened to 11 bits so a sprite near the right/bottom edge clips instead of wrapping.
  logic [10:0] h11, v11;
  logic [10:0] x_lo [4], x_end [4], y_lo [4], y_end [4];
  assign h11 = {1'b0, bus.hpos};
  assign v11 = {1'b0, bus.vpos};

  always_comb begin
    inside_d = '0;
    edge_d   = '0;
    for (int i = 0; i < 4; i++) begin
      x_lo[i]     = {1'b0, sx_q[i]};
      x_end[i]    = x_lo[i] + 11'(BOX_W);
      y_lo[i]     = {2'b00, sy_q[i]};
      y_end[i]    = y_lo[i] + 11'(BOX_H);
      inside_d[i] = (col_q[i] != 3'd0) && bus.video_active &&
                    (h11 < 11'(SCREEN_W)) && (v11 < 11'(SCREEN_H)) &&
                    (h11 >= x_lo[i]) && (h11 < x_end[i]) &&
                    (v11 >= y_lo[i]) && (v11 < y_end[i]);
      edge_d[i]   = inside_d[i] &&
                    ((h11 == x_lo[i]) || (h11 == x_end[i] - 11'd1) ||
                     (v11 == y_lo[i]) || (v11 == y_end[i] - 11'd1));
    end
  end

  function automatic logic [5:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 6'b110000;
      3'd2:    palette = 6'b001100;
      3'd3:    palette = 6'b000011;
      3'd4:    palette = 6'b111100;
      3'd5:    palette = 6'b110011;
      3'd6:    palette = 6'b001111;
      3'd7:    palette = 6'b111111;
      default: palette = 6'b000000;
    endcase
  endfunction

  logic [1:0] win;
  logic [5:0] base;
  logic       multi;

  // Lowest sprite index has the highest priority.
  always_comb begin
    win = 2'd3;
    if (inside_q[2]) win = 2'd2;
    if (inside_q[1]) win = 2'd1;
    if (inside_q[0]) win = 2'd0;
    base  = palette(col_q[win]);
    rgb_d = 6'd0;
    if (active_q) begin
      rgb_d = BG_RGB;
      if (inside_q != 4'd0) begin
        rgb_d = base;
        case (ps_q[win])
          2'd1:    if (edge_q[win]) rgb_d = 6'b111111;
          2'd2:    if (edge_q[win] && frame_cnt_q[3]) rgb_d = 6'b111111;
          2'd3:    if (frame_cnt_q[2]) rgb_d = ~base;
          default: rgb_d = base;
        endcase
      end
    end
  end

  // Two or more bits set <=> clearing the lowest set bit leaves something behind.
  assign multi = |(inside_q & (inside_q - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sx_q[i]  <= '0;
        sy_q[i]  <= '0;
        col_q[i] <= '0;
        ps_q[i]  <= '0;
      end
      frame_cnt_q   <= '0;
      collide_q     <= 1'b0;
      collide_acc_q <= 1'b0;
      inside_q      <= '0;
      edge_q        <= '0;
      active_q      <= 1'b0;
      rgb_q         <= '0;
      pix_valid_q   <= 1'b0;
      hit_q         <= '0;
    end else begin
      if (bus.frame_tick) begin
        for (int i = 0; i < 4; i++) begin
          sx_q[i]  <= posx_in[i];
          sy_q[i]  <= posy_in[i];
          col_q[i] <= col_in[i];
          ps_q[i]  <= ps_in[i];
        end
        frame_cnt_q   <= frame_cnt_q + 5'd1;
        collide_q     <= collide_acc_q;
        collide_acc_q <= 1'b0;
      end else if (multi) begin
        collide_acc_q <= 1'b1;
      end
      inside_q    <= inside_d;
      edge_q      <= edge_d;
      active_q    <= bus.video_active;
      rgb_q       <= rgb_d;
      pix_valid_q <= active_q;
      hit_q       <= inside_q;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.sprite_hit = hit_q;
  assign bus.collide    = collide_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: pixel stream driven one pixel per clock, outputs
// checked exactly two clocks later against hand-derived pixel expectations.
module tb_sprite_compositor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor_if bus();

  sprite_compositor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [4:0]  exp_frame = 5'd0;
  logic [10:0] exp_q[$];   // {pix_valid, sprite_hit[3:0], rgb[5:0]}

  // Samples the outputs left by the previous edge, then drives the next pixel.
  task automatic step(input int x, input int y, input logic act, output logic [10:0] obs);
    @(negedge clk);
    obs = {bus.pix_valid, bus.sprite_hit, bus.rgb};
    bus.hpos = 10'(x);
    bus.vpos = 10'(y);
    bus.video_active = act;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.video_active = 1'b0;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    exp_frame = exp_frame + 5'd1;
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int c, input int p);
    case (i)
      0: begin bus.posx0 = 10'(x); bus.posy0 = 9'(y); bus.color_idx0 = 3'(c); bus.power_state0 = 2'(p); end
      1: begin bus.posx1 = 10'(x); bus.posy1 = 9'(y); bus.color_idx1 = 3'(c); bus.power_state1 = 2'(p); end
      2: begin bus.posx2 = 10'(x); bus.posy2 = 9'(y); bus.color_idx2 = 3'(c); bus.power_state2 = 2'(p); end
      default: begin bus.posx3 = 10'(x); bus.posy3 = 9'(y); bus.color_idx3 = 3'(c); bus.power_state3 = 2'(p); end
    endcase
  endtask

  task automatic test_reset();
    logic [10:0] obs, e0;
    int rows[3];
    rows = '{0, 240, 479};
    checks++; if (bus.rgb !== 6'd0) begin errors++; $display("FAIL rst_rgb got=%b exp=000000", bus.rgb); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid got=%b exp=0", bus.pix_valid); end
    checks++; if (bus.sprite_hit !== 4'd0) begin errors++; $display("FAIL rst_hit got=%b exp=0000", bus.sprite_hit); end
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL rst_collide got=%b exp=0", bus.collide); end
    checks++; if (bus.frame_cnt !== 5'd0) begin errors++; $display("FAIL rst_frame_cnt got=%0d exp=0", bus.frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < 650; x++) begin
        step(x, rows[r], (x < 640), obs);
        exp_q.push_back((x < 640) ? {1'b1, 4'b0000, 6'b000001} : 11'd0);
        if (exp_q.size() > 2) begin
          e0 = exp_q.pop_front(); checks++;
          if (obs !== e0) begin errors++; $display("FAIL t1_bg drive=(%0d,%0d) got=%b exp=%b", x, rows[r], obs, e0); end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
      if (obs !== e0) begin errors++; $display("FAIL t1_flush got=%b exp=%b", obs, e0); end
    end
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL t1_collide got=%b exp=0", bus.collide); end
  endtask

  task automatic test_single();
    logic [10:0] obs, e0;
    logic in0;
    set_spr(0, 100, 100, 1, 0);
    tick();
    checks++; if (bus.frame_cnt !== exp_frame) begin errors++; $display("FAIL t2_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frame); end
    for (int y = 98; y <= 134; y++) begin
      for (int x = 96; x <= 152; x++) begin
        in0 = (x >= 100) && (x <= 147) && (y >= 100) && (y <= 131);
        step(x, y, 1'b1, obs);
        exp_q.push_back({1'b1, 3'b000, in0, in0 ? 6'b110000 : 6'b000001});
        if (exp_q.size() > 2) begin
          e0 = exp_q.pop_front(); checks++;
          if (obs !== e0) begin errors++; $display("FAIL t2_pix drive=(%0d,%0d) got=%b exp=%b", x, y, obs, e0); end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
      if (obs !== e0) begin errors++; $display("FAIL t2_flush got=%b exp=%b", obs, e0); end
    end
  endtask

  task automatic test_overlap();
    logic [10:0] obs, e0;
    logic in0, in1;
    int s1x;
    set_spr(1, 120, 110, 2, 0);
    tick();
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL t3_collide_single got=%b exp=0", bus.collide); end
    for (int pass = 0; pass < 3; pass++) begin
      s1x = (pass < 2) ? 120 : 300;
      for (int y = 105; y <= 145; y++) begin
        for (int x = 95; x <= 175; x++) begin
          in0 = (x >= 100) && (x <= 147) && (y >= 100) && (y <= 131);
          in1 = (x >= s1x) && (x < s1x + 48) && (y >= 110) && (y <= 141);
          step(x, y, 1'b1, obs);
          exp_q.push_back({1'b1, 2'b00, in1, in0, in0 ? 6'b110000 : (in1 ? 6'b001100 : 6'b000001)});
          if (exp_q.size() > 2) begin
            e0 = exp_q.pop_front(); checks++;
            if (obs !== e0) begin errors++; $display("FAIL t3_pix pass=%0d drive=(%0d,%0d) got=%b exp=%b", pass, x, y, obs, e0); end
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
        if (obs !== e0) begin errors++; $display("FAIL t3_flush got=%b exp=%b", obs, e0); end
      end
      tick();
      checks++;
      if (bus.collide !== (pass < 2)) begin errors++; $display("FAIL t3_collide pass=%0d got=%b exp=%b", pass, bus.collide, (pass < 2)); end
      if (pass == 0) bus.posx1 = 10'd300;
    end
  endtask

  task automatic test_power();
    logic [10:0] obs, e0;
    logic in0, edg, white, inv;
    int ys[7];
    ys = '{99, 100, 101, 115, 130, 131, 132};
    set_spr(1, 0, 0, 0, 0);
    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0: begin set_spr(0, 100, 100, 1, 1); tick(); white = 1'b1; inv = 1'b0; end
        1: begin set_spr(0, 100, 100, 1, 2); tick(); while (exp_frame[3] != 1'b0) tick(); white = 1'b0; inv = 1'b0; end
        2: begin tick(); while (exp_frame[3] != 1'b1) tick(); white = 1'b1; inv = 1'b0; end
        3: begin set_spr(0, 100, 100, 1, 3); tick(); while (exp_frame[2] != 1'b0) tick(); white = 1'b0; inv = 1'b0; end
        default: begin tick(); while (exp_frame[2] != 1'b1) tick(); white = 1'b0; inv = 1'b1; end
      endcase
      checks++; if (bus.frame_cnt !== exp_frame) begin errors++; $display("FAIL t4_frame_cnt ph=%0d got=%0d exp=%0d", ph, bus.frame_cnt, exp_frame); end
      for (int r = 0; r < 7; r++) begin
        for (int x = 98; x <= 150; x++) begin
          in0 = (x >= 100) && (x <= 147) && (ys[r] >= 100) && (ys[r] <= 131);
          edg = in0 && ((x == 100) || (x == 147) || (ys[r] == 100) || (ys[r] == 131));
          step(x, ys[r], 1'b1, obs);
          exp_q.push_back({1'b1, 3'b000, in0, !in0 ? 6'b000001 : inv ? 6'b001111 : (white && edg) ? 6'b111111 : 6'b110000});
          if (exp_q.size() > 2) begin
            e0 = exp_q.pop_front(); checks++;
            if (obs !== e0) begin errors++; $display("FAIL t4_pix ph=%0d drive=(%0d,%0d) got=%b exp=%b", ph, x, ys[r], obs, e0); end
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
        if (obs !== e0) begin errors++; $display("FAIL t4_flush got=%b exp=%b", obs, e0); end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [10:0] obs, e0;
    logic in0;
    int left;
    set_spr(0, 100, 100, 1, 0);
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      left = (pass == 0) ? 100 : 200;
      for (int x = 95; x <= 260; x++) begin
        in0 = (x >= left) && (x < left + 48);
        step(x, 110, 1'b1, obs);
        if (pass == 0 && x == 120) bus.posx0 = 10'd200;
        exp_q.push_back({1'b1, 3'b000, in0, in0 ? 6'b110000 : 6'b000001});
        if (exp_q.size() > 2) begin
          e0 = exp_q.pop_front(); checks++;
          if (obs !== e0) begin errors++; $display("FAIL t5_pix pass=%0d drive_x=%0d got=%b exp=%b", pass, x, obs, e0); end
        end
      end
      for (int k = 0; k < 2; k++) begin
        step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
        if (obs !== e0) begin errors++; $display("FAIL t5_flush got=%b exp=%b", obs, e0); end
      end
      if (pass == 0) tick();
    end
  endtask

  task automatic test_frame_wrap();
    while (exp_frame != 5'd31) tick();
    checks++; if (bus.frame_cnt !== 5'd31) begin errors++; $display("FAIL wrap_31 got=%0d exp=31", bus.frame_cnt); end
    tick();
    checks++; if (bus.frame_cnt !== 5'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", bus.frame_cnt); end
  endtask

  task automatic test_clip_reset();
    logic [10:0] obs, e0;
    logic in0, in1;
    int x;
    set_spr(0, 620, 460, 1, 0);
    set_spr(1, 630, 470, 2, 0);
    tick();
    for (int y = 458; y <= 479; y++) begin
      for (int k = 0; k < 35; k++) begin
        x = (k < 5) ? k : 605 + k;
        in0 = (x >= 620) && (y >= 460);
        in1 = (x >= 630) && (y >= 470);
        step(x, y, 1'b1, obs);
        exp_q.push_back({1'b1, 2'b00, in1, in0, in0 ? 6'b110000 : (in1 ? 6'b001100 : 6'b000001)});
        if (exp_q.size() > 2) begin
          e0 = exp_q.pop_front(); checks++;
          if (obs !== e0) begin errors++; $display("FAIL t6_clip drive=(%0d,%0d) got=%b exp=%b", x, y, obs, e0); end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
      if (obs !== e0) begin errors++; $display("FAIL t6_flush got=%b exp=%b", obs, e0); end
    end
    tick();
    checks++; if (bus.collide !== 1'b1) begin errors++; $display("FAIL t6_collide_pre got=%b exp=1", bus.collide); end
    for (int xx = 630; xx < 640; xx++) step(xx, 475, 1'b1, obs);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rgb !== 6'd0) begin errors++; $display("FAIL t6_rst_rgb got=%b exp=000000", bus.rgb); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_pix_valid got=%b exp=0", bus.pix_valid); end
    checks++; if (bus.sprite_hit !== 4'd0) begin errors++; $display("FAIL t6_rst_hit got=%b exp=0000", bus.sprite_hit); end
    checks++; if (bus.frame_cnt !== 5'd0) begin errors++; $display("FAIL t6_rst_frame_cnt got=%0d exp=0", bus.frame_cnt); end
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL t6_rst_collide got=%b exp=0", bus.collide); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_frame = 5'd0;
    for (int xx = 600; xx < 640; xx++) begin
      step(xx, 475, 1'b1, obs);
      exp_q.push_back({1'b1, 4'b0000, 6'b000001});
      if (exp_q.size() > 2) begin
        e0 = exp_q.pop_front(); checks++;
        if (obs !== e0) begin errors++; $display("FAIL t6_disabled drive_x=%0d got=%b exp=%b", xx, obs, e0); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1'b0, obs); e0 = exp_q.pop_front(); checks++;
      if (obs !== e0) begin errors++; $display("FAIL t6_flush2 got=%b exp=%b", obs, e0); end
    end
    tick();
    checks++; if (bus.frame_cnt !== exp_frame) begin errors++; $display("FAIL t6_frame_after got=%0d exp=%0d", bus.frame_cnt, exp_frame); end
    checks++; if (bus.collide !== 1'b0) begin errors++; $display("FAIL t6_collide_after got=%b exp=0", bus.collide); end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.video_active = 1'b0;
    bus.hpos = '0;
    bus.vpos = '0;
    for (int i = 0; i < 4; i++) set_spr(i, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_overlap();
    test_power();
    test_snapshot();
    test_frame_wrap();
    test_clip_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
